// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the operand-A issue path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    // Encoding shared with operand_A_select
    typedef enum logic [1:0] {
        OPA_RS1  = 2'b00,
        OPA_PC   = 2'b01,
        OPA_ZERO = 2'b10,
        OPA_PC4  = 2'b11
    } opa_sel_e;

    // Number of operands held by the issue stage
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_e;

    localparam int unsigned PC_INC = 4;

endpackage : core_pkg

`default_nettype wire

// File: rtl/opa_resolve.sv
// ============================================================================
// Module      : opa_resolve
// Description : Combinational operand-A select: rs1/forward, PC, zero, PC+4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opa_resolve
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  opa_sel_e          opasel_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              fwd_en_i,
    input  logic [XLEN-1:0]   fwd_data_i,
    output logic [XLEN-1:0]   opa_o
);

    logic [XLEN-1:0] rs1_eff;
    logic [XLEN-1:0] pc_plus_inc;

    assign rs1_eff     = fwd_en_i ? fwd_data_i : rs1_data_i;
    // Wraps at the top of the address space, matching the ISA PC arithmetic
    assign pc_plus_inc = pc_i + XLEN'(PC_INC);

    always_comb begin
        opa_o = '0;
        case (opasel_i)
            OPA_RS1:  opa_o = rs1_eff;
            OPA_PC:   opa_o = pc_i;
            OPA_ZERO: opa_o = '0;
            OPA_PC4:  opa_o = pc_plus_inc;
            default:  opa_o = '0;
        endcase
    end

endmodule : opa_resolve

`default_nettype wire

// File: rtl/opa_issue_stage.sv
// ============================================================================
// Module      : opa_issue_stage
// Description : Resolves operand A and registers it into ID/EX through a
//               two-entry skid buffer with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opa_issue_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        opasel_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              fwd_en_i,
    input  logic [XLEN-1:0]   fwd_data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   opa_o
);

    skid_state_e       state_q, state_d;
    logic [XLEN-1:0]   main_q, main_d;
    logic [XLEN-1:0]   skid_q, skid_d;
    logic [XLEN-1:0]   opa_resolved;
    logic              in_xfer;
    logic              out_xfer;

    opa_resolve #(
        .XLEN       (XLEN)
    ) u_resolve (
        .opasel_i   (opa_sel_e'(opasel_i)),
        .rs1_data_i (rs1_data_i),
        .pc_i       (pc_i),
        .fwd_en_i   (fwd_en_i),
        .fwd_data_i (fwd_data_i),
        .opa_o      (opa_resolved)
    );

    // Handshake outputs decode the state register only, so ready_o never
    // depends combinationally on ready_i.
    assign valid_o  = (state_q != EMPTY);
    assign ready_o  = (state_q != SKID);
    assign opa_o    = main_q;

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = opa_resolved;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_d  = opa_resolved;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = opa_resolved;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule : opa_issue_stage

`default_nettype wire

// File: tb/tb_opa_issue_stage.sv
// ============================================================================
// Module      : tb_opa_issue_stage
// Description : Self-checking bench for opa_issue_stage against a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_opa_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  opasel;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic        fwd_en;
    logic [31:0] fwd_data;
    logic        flush;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] opa_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a FIFO of at most two operands; head is what execute sees
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    opa_issue_stage #(
        .XLEN       (32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .opasel_i   (opasel),
        .rs1_data_i (rs1_data),
        .pc_i       (pc),
        .fwd_en_i   (fwd_en),
        .fwd_data_i (fwd_data),
        .flush_i    (flush),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .opa_o      (opa_o)
    );

    function automatic logic [31:0] ref_opa(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [31:0] p, input logic fe,
                                            input logic [31:0] fd);
        logic [32:0] sum;
        sum = {1'b0, p} + 33'd4;
        case (sel)
            2'd0:    return fe ? fd : r;
            2'd1:    return p;
            2'd2:    return 32'd0;
            default: return sum[31:0];
        endcase
    endfunction

    // Advance one clock and update the model with the inputs present at the edge
    task automatic tick();
        bit          in_x;
        bit          out_x;
        logic [31:0] dummy;
        in_x  = valid_i && (mq.size() < 2);
        out_x = (mq.size() > 0) && ready_i;
        @(posedge clk);
        #1;
        if (out_x) dummy = mq.pop_front();
        if (flush) mq.delete();
        else if (in_x) mq.push_back(ref_opa(opasel, rs1_data, pc, fwd_en, fwd_data));
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] r,
                         input logic [31:0] p, input logic fe, input logic [31:0] fd);
        valid_i  = v;
        opasel   = sel;
        rs1_data = r;
        pc       = p;
        fwd_en   = fe;
        fwd_data = fd;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        ready_i = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || opa_o !== 32'h0)
            $display("FAIL reset_state: valid_o=%b ready_o=%b opa_o=%h, required 0 1 00000000",
                     valid_o, ready_o, opa_o);
        else n_pass++;
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 32'h1234, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || opa_o !== 32'h1234)
            $display("FAIL single_op: valid_o=%b opa_o=%h, required 1 00001234", valid_o, opa_o);
        else n_pass++;
        valid_i = 1'b0;
        tick();
        n_checks++;
        if (valid_o !== 1'b0)
            $display("FAIL single_op_drain: valid_o=%b, required 0", valid_o);
        else n_pass++;
    endtask

    task automatic test_select();
        logic [1:0]  sels[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        logic [31:0] pcs[5]  = '{32'h80000010, 32'h80000010, 32'h80000010,
                                 32'h80000010, 32'hFFFFFFFC};
        logic [31:0] exps[5] = '{32'h0000AAAA, 32'h80000010, 32'h00000000,
                                 32'h80000014, 32'h00000000};
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sels[i], 32'h5555, pcs[i], 1'b1, 32'hAAAA);
            tick();
            n_checks++;
            if (valid_o !== 1'b1 || opa_o !== exps[i])
                $display("FAIL select_%0d: valid_o=%b opa_o=%h, required 1 %h",
                         i, valid_o, opa_o, exps[i]);
            else n_pass++;
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_skid();
        ready_i = 1'b0;
        drive(1'b1, 2'd0, 32'h1, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 2'd0, 32'h2, 32'h0, 1'b0, 32'h0);
        tick();
        n_checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || opa_o !== 32'h1)
            $display("FAIL skid_fill: ready_o=%b valid_o=%b opa_o=%h, required 0 1 00000001",
                     ready_o, valid_o, opa_o);
        else n_pass++;
        valid_i = 1'b0;
        tick();
        n_checks++;
        if (ready_o !== 1'b0 || opa_o !== 32'h1)
            $display("FAIL skid_hold: ready_o=%b opa_o=%h, required 0 00000001", ready_o, opa_o);
        else n_pass++;
        ready_i = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || opa_o !== 32'h2 || ready_o !== 1'b1)
            $display("FAIL skid_drain: valid_o=%b opa_o=%h ready_o=%b, required 1 00000002 1",
                     valid_o, opa_o, ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (valid_o !== 1'b0)
            $display("FAIL skid_empty: valid_o=%b, required 0", valid_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'd0, 32'(i), 32'h0, 1'b0, 32'h0);
            tick();
            n_checks++;
            if (valid_o !== 1'b1 || opa_o !== 32'(i) || ready_o !== 1'b1)
                $display("FAIL throughput_%0d: valid_o=%b opa_o=%h ready_o=%b, required 1 %h 1",
                         i, valid_o, opa_o, ready_o, 32'(i));
            else n_pass++;
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive(1'b1, 2'd0, 32'h11, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 2'd0, 32'h22, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 2'd0, 32'h33, 32'h0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL flush_skid: valid_o=%b ready_o=%b, required 0 1", valid_o, ready_o);
        else n_pass++;
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (valid_o !== 1'b0)
                $display("FAIL flush_no_leak_%0d: valid_o=%b opa_o=%h, required valid_o 0",
                         i, valid_o, opa_o);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        drive(1'b1, 2'd1, 32'h0, 32'h77, 1'b0, 32'h0);
        tick();
        valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || opa_o !== 32'h77)
            $display("FAIL async_pre: valid_o=%b opa_o=%h, required 1 00000077", valid_o, opa_o);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        n_checks++;
        if (valid_o !== 1'b0 || opa_o !== 32'h0 || ready_o !== 1'b1)
            $display("FAIL async_reset: valid_o=%b opa_o=%h ready_o=%b, required 0 00000000 1",
                     valid_o, opa_o, ready_o);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom,
                  1'($urandom_range(0, 1)), $urandom);
            ready_i = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++;
            if (valid_o !== (mq.size() > 0) || ready_o !== (mq.size() < 2) ||
                (mq.size() > 0 && opa_o !== mq[0]))
                $display("FAIL random_%0d: valid_o=%b ready_o=%b opa_o=%h, required %b %b %h",
                         i, valid_o, ready_o, opa_o, mq.size() > 0, mq.size() < 2,
                         (mq.size() > 0) ? mq[0] : 32'h0);
            else n_pass++;
        end
        flush   = 1'b0;
        valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_select();
        test_skid();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_opa_issue_stage

`default_nettype wire
